// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM-port arbiter that time-shares the
// data RAM between the MEM stage and the LED refresh scan.
package ram_arb_pkg;

  localparam int LED_DEPTH = 16;
  localparam int LED_IDX_W = 4;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_PEND = 2'd1,
    S_SCAN = 2'd2
  } arb_state_e;

  // The LED buffer shadows the first LED_DEPTH words of the address space.
  function automatic logic is_led_addr(input logic [31:0] addr);
    return addr[31:LED_IDX_W+2] == '0;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// CPU, RAM and LED-display signals of the arbiter; slave is the arbiter side,
// master is the surrounding pipeline/RAM/display side.
interface ram_arbiter_if;
  import ram_arb_pkg::*;

  logic                 cpu_req;
  logic                 cpu_we;
  logic                 cpu_lh;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_stall;
  logic [LED_IDX_W-1:0] addr_ledin;
  logic [31:0]          led_out;
  logic [31:0]          ram_addr;
  logic [31:0]          ram_wdata;
  logic                 ram_we;
  logic                 ram_lh;
  logic [31:0]          ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_lh, cpu_addr, cpu_wdata, addr_ledin, ram_rdata,
    output cpu_rdata, cpu_stall, led_out, ram_addr, ram_wdata, ram_we, ram_lh
  );

  modport master (
    output cpu_req, cpu_we, cpu_lh, cpu_addr, cpu_wdata, addr_ledin, ram_rdata,
    input  cpu_rdata, cpu_stall, led_out, ram_addr, ram_wdata, ram_we, ram_lh
  );

endinterface

// File: rtl/ram_arbiter_scan_timer.sv
// Period and starvation counters that decide when an LED scan is due and when
// a pending scan must take the RAM port away from the CPU.
module scan_timer #(
  parameter int SCAN_PERIOD  = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  input  logic in_pend,
  input  logic cpu_req,
  output logic scan_due,
  output logic starve
);

  localparam int PW = $clog2(SCAN_PERIOD + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [PW-1:0] DUE_AT    = PW'(SCAN_PERIOD - 1);
  localparam logic [SW-1:0] STARVE_AT = SW'(STARVE_LIMIT);

  logic [PW-1:0] period_q, period_d, period_inc;
  logic [SW-1:0] wait_q, wait_d;

  // Due fires on the cycle the count reaches SCAN_PERIOD-1, so an idle bus
  // sees one scan every SCAN_PERIOD+1 cycles (wait cycles + pend + scan).
  always_comb begin
    period_inc = period_q + 1'b1;
    scan_due   = in_wait && (period_inc == DUE_AT);
    starve     = in_pend && (wait_q == STARVE_AT);
    period_d   = period_q;
    wait_d     = '0;
    if (in_wait) begin
      period_d = scan_due ? '0 : period_inc;
    end
    // Counting stops at the limit because reaching it forces the scan.
    if (in_pend && cpu_req && !starve) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      wait_q   <= '0;
    end else begin
      period_q <= period_d;
      wait_q   <= wait_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between the MEM stage and a periodic LED scan,
// and keeps a 16-word LED buffer refreshed by scans and mirrored CPU stores.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int SCAN_PERIOD  = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  arb_state_e           state_q, state_d;
  logic [LED_IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [31:0]          led_buf_q [LED_DEPTH];
  logic [31:0]          led_buf_d [LED_DEPTH];
  logic                 scan_due, starve;
  logic                 cpu_grant, mirror_en;

  scan_timer #(
    .SCAN_PERIOD (SCAN_PERIOD),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_scan_timer (
    .clk     (clk),
    .rst     (rst),
    .in_wait (state_q == S_WAIT),
    .in_pend (state_q == S_PEND),
    .cpu_req (bus.cpu_req),
    .scan_due(scan_due),
    .starve  (starve)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (scan_due) state_d = S_PEND;
      S_PEND:  if (!bus.cpu_req || starve) state_d = S_SCAN;
      S_SCAN:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // A scan capture and a mirror write never collide: the CPU owns the port
  // in every state except S_SCAN.
  always_comb begin
    cpu_grant  = (state_q != S_SCAN);
    mirror_en  = cpu_grant && bus.cpu_req && bus.cpu_we && !bus.cpu_lh &&
                 is_led_addr(bus.cpu_addr);
    scan_idx_d = cpu_grant ? scan_idx_q : scan_idx_q + 1'b1;
    led_buf_d  = led_buf_q;
    if (!cpu_grant) begin
      led_buf_d[scan_idx_q] = bus.ram_rdata;
    end else if (mirror_en) begin
      led_buf_d[bus.cpu_addr[LED_IDX_W+1:2]] = bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT;
      scan_idx_q <= '0;
      led_buf_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      led_buf_q  <= led_buf_d;
    end
  end

  always_comb begin
    bus.ram_addr  = cpu_grant ? bus.cpu_addr
                              : {{(30 - LED_IDX_W){1'b0}}, scan_idx_q, 2'b00};
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_we    = !rst && cpu_grant && bus.cpu_req && bus.cpu_we;
    bus.ram_lh    = cpu_grant && bus.cpu_lh;
    bus.cpu_stall = !rst && !cpu_grant && bus.cpu_req;
    bus.cpu_rdata = cpu_grant ? bus.ram_rdata : '0;
    bus.led_out   = led_buf_q[bus.addr_ledin];
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vectors and corner sequences, then random
// traffic against a cycle-level reference model of the scan schedule.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int SP = 8;
  localparam int SL = 4;
  localparam logic [31:0] FAR_ADDR = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter #(
    .SCAN_PERIOD (SP),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External RAM: asynchronous read, synchronous write, 256 words.
  logic [31:0] mem [256];
  assign bus.ram_rdata = mem[bus.ram_addr[9:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 3) ? 32'h1234_5678 : 32'hA000_0000 + 32'(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    end
  end

  // Reference model: how many idle cycles have elapsed, whether a scan is
  // pending, how long it has been starved, and what the LED words hold.
  int          m_wait, m_starve, m_idx;
  bit          m_pend, m_scan;
  logic [31:0] m_led [16];

  task automatic model_update();
    if (rst) begin
      m_wait = 0; m_starve = 0; m_idx = 0; m_pend = 0; m_scan = 0;
      for (int i = 0; i < 16; i++) m_led[i] = '0;
    end else if (m_scan) begin
      m_led[m_idx] = mem[m_idx];
      m_idx  = (m_idx + 1) % 16;
      m_scan = 0;
    end else begin
      if (bus.cpu_req && bus.cpu_we && !bus.cpu_lh && bus.cpu_addr < 32'd64)
        m_led[bus.cpu_addr[5:2]] = bus.cpu_wdata;
      if (m_pend) begin
        if (!bus.cpu_req || m_starve >= SL) begin
          m_scan = 1; m_pend = 0; m_starve = 0;
        end else begin
          m_starve++;
        end
      end else begin
        m_wait++;
        if (m_wait == SP - 1) begin
          m_pend = 1; m_wait = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic req, input logic we, input logic lh,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_lh = lh;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.addr_ledin = sel;
  endtask

  // One clock: compare combinational outputs to the model, clock, advance model.
  task automatic step(output logic [31:0] s_addr, output logic [31:0] s_rdata,
                      output logic [31:0] s_led, output logic s_stall);
    logic [31:0] e_addr;
    #2;
    e_addr = m_scan ? 32'(m_idx) << 2 : bus.cpu_addr;
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("ram_we", 32'(bus.ram_we), 32'(!rst && !m_scan && bus.cpu_req && bus.cpu_we));
    chk("ram_lh", 32'(bus.ram_lh), 32'(!m_scan && bus.cpu_lh));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(!rst && m_scan && bus.cpu_req));
    chk("cpu_rdata", bus.cpu_rdata, m_scan ? 32'h0 : mem[e_addr[9:2]]);
    chk("led_out", bus.led_out, m_led[bus.addr_ledin]);
    s_addr = bus.ram_addr; s_rdata = bus.cpu_rdata; s_led = bus.led_out; s_stall = bus.cpu_stall;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        req, we, lh;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] exp_rdata;
    logic        exp_stall;
    logic [31:0] exp_led;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] a, r, l;
  logic        s;
  int          nstall, stall_cyc, nscan;
  logic [31:0] stall_addr;

  task automatic do_reset(input int n);
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 32'h14, 32'hFFFF_0000, 4'd5);
    for (int i = 0; i < n; i++) step(a, r, l, s);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_wait = 0; m_starve = 0; m_idx = 0; m_pend = 0; m_scan = 0;
    for (int i = 0; i < 16; i++) m_led[i] = '0;
    preload = 1'b1; rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(posedge clk); #1;
    preload = 1'b0;

    // Reset held with a store request: no stall, no RAM write.
    do_reset(3);

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'hDEAD_BEEF, 4'd5,  32'hA000_0005, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFE_F00D, 4'd0,  32'hA000_0010, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h1111_2222, 4'd2,  32'hA000_0002, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0C, 32'h0,         4'd5,  32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h14, 32'h0,         4'd2,  32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h3C, 32'h0BAD_F00D, 4'd15, 32'hA000_000F, 1'b0, 32'h0BAD_F00D};
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].req, vecs[i].we, vecs[i].lh, vecs[i].addr, vecs[i].wdata, vecs[i].sel);
      step(a, r, l, s);
      chk("vec_rdata", r, vecs[i].exp_rdata);
      chk("vec_stall", 32'(s), 32'(vecs[i].exp_stall));
      chk("vec_led_next", bus.led_out, vecs[i].exp_led);
    end

    // Continuous CPU traffic: pend entered at cycle 7, forced scan at cycle 12.
    nstall = 0; stall_cyc = -1; stall_addr = '1;
    set_in(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'd0);
    for (int c = 6; c < 25; c++) begin
      step(a, r, l, s);
      if (s) begin nstall++; stall_cyc = c; stall_addr = a; end
    end
    chk("starve_stall_count", 32'(nstall), 32'd1);
    chk("starve_stall_cycle", 32'(stall_cyc), 32'd12);
    chk("starve_scan_addr", stall_addr, 32'h0);

    // Idle bus: a scan every SP+1 cycles, index wrapping after 15.
    do_reset(2);
    set_in(1'b1, 1'b1, 1'b1, 32'h08, 32'h7777_8888, 4'd2);
    step(a, r, l, s);
    set_in(1'b0, 1'b0, 1'b0, FAR_ADDR, 32'h0, 4'd2);
    nscan = 0;
    for (int c = 1; c <= 160; c++) begin
      step(a, r, l, s);
      if (c == 20) chk("lh_store_not_mirrored", l, 32'h0);
      if (a != FAR_ADDR) begin
        chk("scan_cycle", 32'(c), 32'(9 * nscan + 8));
        chk("scan_addr", a, 32'((nscan % 16) * 4));
        nscan++;
      end
    end
    chk("scan_total", 32'(nscan), 32'd17);
    for (int i = 0; i < 16; i++) begin
      bus.addr_ledin = 4'(i);
      step(a, r, l, s);
      chk("led_matches_ram", bus.led_out, mem[i]);
    end

    // Reset landing on the scan cycle discards the capture.
    do_reset(2);
    set_in(1'b1, 1'b1, 1'b0, 32'h04, 32'h1357_9BDF, 4'd1);
    step(a, r, l, s);
    set_in(1'b0, 1'b0, 1'b0, FAR_ADDR, 32'h0, 4'd1);
    for (int c = 1; c < 8; c++) step(a, r, l, s);
    chk("pre_reset_led1", bus.led_out, 32'h1357_9BDF);
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, FAR_ADDR, 32'h5555_5555, 4'd0);
    step(a, r, l, s);
    chk("rst_scan_addr", a, 32'h0);
    chk("rst_scan_stall", 32'(s), 32'd0);
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, FAR_ADDR, 32'h0, 4'd0);
    for (int c = 0; c <= 8; c++) begin
      if (c == 1) set_in(1'b0, 1'b0, 1'b0, FAR_ADDR, 32'h0, 4'd1);
      step(a, r, l, s);
      if (c == 0) begin
        chk("post_rst_no_capture", l, 32'h0);
        chk("post_rst_stall", 32'(s), 32'd0);
      end
      if (c == 1) chk("post_rst_led1", l, 32'h0);
      chk("post_rst_addr", a, (c == 8) ? 32'h0 : FAR_ADDR);
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31)) * 4,
             32'($urandom), 4'($urandom_range(0, 15)));
      step(a, r, l, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter SCAN_PERIOD, default 1024, meaning the cycle count between LED-scan requests.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of cycles a pending scan may wait before it forces the port.
REQ-003 SHALL have port clk, input, 1, the single system clock (rising edge).
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port cpu_req, input, 1, MEM-stage access request (memread or memw active).
REQ-006 SHALL have port cpu_we, input, 1, MEM-stage write enable.
REQ-007 SHALL have port cpu_lh, input, 1, MEM-stage halfword-load flag, passed through to the RAM.
REQ-008 SHALL have port cpu_addr, input, 32, MEM-stage byte address (ALU result).
REQ-009 SHALL have port cpu_wdata, input, 32, MEM-stage store data.
REQ-010 SHALL have port cpu_rdata, output, 32, load data returned to the MEM stage.
REQ-011 SHALL have port cpu_stall, output, 1, freezes the pipeline in the cycle a scan owns the port.
REQ-012 SHALL have port addr_ledin, input, 4, selects which LED buffer word is displayed.
REQ-013 SHALL have port led_out, output, 32, the selected LED buffer word.
REQ-014 SHALL have ports ram_addr (32), ram_wdata (32), ram_we (1) and ram_lh (1) as outputs, plus ram_rdata (32) as input, forming the single RAM port (asynchronous read, synchronous write).

Function
REQ-015 SHALL hold a 16x32 LED buffer (led_buf), a 4-bit scan index (scan_idx), a period counter and a 3-state FSM {S_WAIT, S_PEND, S_SCAN}.
REQ-016 SHALL stay in S_WAIT, incrementing the period counter, and SHALL go to S_PEND and clear the counter when the counter reaches SCAN_PERIOD-1.
REQ-017 In S_PEND, SHALL go to S_SCAN when cpu_req=0 in that cycle; otherwise it SHALL increment the wait counter.
REQ-018 In S_PEND, SHALL go to S_SCAN when the wait counter reaches STARVE_LIMIT.
REQ-019 In S_SCAN, SHALL drive ram_addr={26'b0,scan_idx,2'b00}, ram_we=0 and ram_lh=0.
REQ-020 In S_SCAN, SHALL capture led_buf[scan_idx]<=ram_rdata, increment scan_idx (wrapping 15->0) and return to S_WAIT; the state lasts exactly 1 cycle.
REQ-021 cpu_stall SHALL be combinational: 1 only when the state is S_SCAN and cpu_req=1; otherwise 0.
REQ-022 When the state is not S_SCAN, SHALL connect the CPU signals straight to the RAM: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we&cpu_req, ram_lh=cpu_lh.
REQ-023 cpu_rdata SHALL equal ram_rdata when the CPU is granted, and 0 otherwise (zero-latency load).
REQ-024 Mirroring: on a granted CPU write with cpu_lh=0 and cpu_addr[31:6]=0, SHALL write led_buf[cpu_addr[5:2]]<=cpu_wdata in the same edge.
REQ-025 SHALL NOT mirror writes with cpu_lh=1; the scan refreshes those words.
REQ-026 led_out SHALL equal led_buf[addr_ledin] combinationally.
REQ-027 Simultaneous events: a scan capture and a mirror write to the same index cannot coincide, because the CPU is never granted in S_SCAN.
REQ-028 Simultaneous events: a mirror write to a non-scanned index proceeds normally.
REQ-029 The wait counter SHALL saturate; STARVE_LIMIT=0 means the scan always forces the port on its first S_PEND cycle.

Reset
REQ-030 When rst=1 at a clock edge, SHALL set state=S_WAIT and clear all counters, scan_idx and every led_buf entry to 0.
REQ-031 Reset mid-operation, including in S_SCAN, SHALL discard the pending capture.
REQ-032 While rst=1, SHALL drive cpu_stall=0 and ram_we=0.
REQ-033 After reset, SHALL drive cpu_rdata=ram_rdata pass-through and led_out=0.

Structure
REQ-034 SHALL place the FSM state encoding and the led_buf depth/index width constants (16, 4) in shared package ram_arb_pkg.
REQ-035 SHALL implement the period/starvation counting as one sub-module, scan_timer (outputs scan_due and starve).
REQ-036 SHALL contain no RAM instance; the RAM stays external.

Verification
REQ-037 SHALL cover: SCAN_PERIOD=8, cpu_req=0 throughout -> a scan on every 9th cycle, with scan_idx 0..15 then wrapping to 0; led_buf matches RAM words 0..15.
REQ-038 SHALL cover: cpu_req=1 continuously with STARVE_LIMIT=4 -> cpu_stall=1 for exactly 1 cycle, 5 cycles after S_PEND is entered, with ram_addr=scan_idx*4.
REQ-039 SHALL cover: a CPU store of 0xDEADBEEF to 0x14 (lh=0) -> led_buf[5]=0xDEADBEEF on the next cycle, and led_out=0xDEADBEEF with addr_ledin=5.
REQ-040 SHALL cover: a CPU store to 0x40 -> no led_buf change; a halfword-flagged store to 0x8 -> led_buf[2] unchanged until the next scan of index 2.
REQ-041 SHALL cover: rst=1 asserted during S_SCAN -> the next cycle has state S_WAIT, scan_idx=0, led_out=0, cpu_stall=0, and no capture.
REQ-042 SHALL cover: a load from 0x0C with a RAM word of 0x12345678 in S_WAIT -> cpu_rdata=0x12345678 in the same cycle with cpu_stall=0.
